// File: rtl/xor_descrambler.sv
// rtl/xor_descrambler.sv - Valid/ready XOR descrambler using a reseedable 16-bit LFSR keystream.
// Optional out_parity port is enabled with XOR_DESCRAMBLER_PARITY_EN.
module xor_descrambler #(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      word_count
`ifdef XOR_DESCRAMBLER_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [15:0]      count_q, count_d;
    logic             accept;
    logic             fb;
    logic [WIDTH-1:0] plain;

    assign out_valid  = (state_q == FULL);
    // Reseeding blocks input so a word is never descrambled with a half-updated keystream.
    assign in_ready   = !seed_load && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign fb         = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign plain      = in_data ^ lfsr_q[WIDTH-1:0];
    assign out_data   = data_q;
    assign word_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            lfsr_q  <= SEED;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        count_d = count_q;

        // A zero seed would lock the LFSR at zero, so fall back to SEED.
        if (seed_load) begin
            lfsr_d = (seed == 16'h0000) ? SEED : seed;
        end else if (accept) begin
            lfsr_d = {lfsr_q[14:0], fb};
        end

        if (accept) begin
            data_d  = plain;
            count_d = count_q + 16'd1;
        end

        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

`ifdef XOR_DESCRAMBLER_PARITY_EN
    logic parity_q;

    assign out_parity = parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^plain;
        end
    end
`endif

endmodule

// File: tb/tb_xor_descrambler.sv
// tb/tb_xor_descrambler.sv - Scoreboard bench for xor_descrambler against a keystream reference model.
module tb_xor_descrambler;

    logic        clk;
    logic        rst_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] word_count;
`ifdef XOR_DESCRAMBLER_PARITY_EN
    logic        out_parity;
`endif

    xor_descrambler #(
        .WIDTH(8),
        .SEED (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_count(word_count)
`ifdef XOR_DESCRAMBLER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  sb[$];
    logic [15:0] m_lfsr;
    logic        m_full;
    logic [15:0] m_count;

    // Fibonacci LFSR with taps 16,14,13,11 expressed as masked parity.
    function automatic logic [15:0] next_key(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_full  = 1'b0;
        m_count = 16'h0000;
        sb.delete();
    endtask

    // One clock cycle of stimulus: drive at negedge+1, judge acceptance at negedge+2.
    task automatic drive(input logic v, input logic [7:0] d, input logic ordy,
                         input logic sl, input logic [15:0] sd);
        logic exp_ready;
        @(negedge clk);
        #1;
        in_valid  = v;
        in_data   = v ? d : 8'hxx;
        out_ready = ordy;
        seed_load = sl;
        seed      = sd;
        #1;
        exp_ready = !sl && (!m_full || ordy);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        if (sl) m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
        if (v && exp_ready) begin
            sb.push_back(d ^ m_lfsr[7:0]);
            m_lfsr  = next_key(m_lfsr);
            m_count = m_count + 16'd1;
            m_full  = 1'b1;
        end else if (ordy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word is consumed at the edge following a cycle with out_valid && out_ready.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {24'b0, out_data}, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    chk("sb_out_data", {24'b0, out_data}, {24'b0, e});
`ifdef XOR_DESCRAMBLER_PARITY_EN
                    chk("sb_out_parity", {31'b0, out_parity}, {31'b0, ^e});
`endif
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_word_count", {16'b0, word_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First word, then a stall with input pending.
        drive(1'b1, 8'h00, 1'b1, 1'b0, 16'h0);
        after_edge();
        chk("first_out_data", {24'b0, out_data}, 32'h0000_00E1);
        chk("first_out_valid", {31'b0, out_valid}, 32'd1);
        chk("first_count", {16'b0, word_count}, 32'd1);
`ifdef XOR_DESCRAMBLER_PARITY_EN
        chk("parity_e1", {31'b0, out_parity}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h55, 1'b0, 1'b0, 16'h0);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            after_edge();
            chk("stall_out_data", {24'b0, out_data}, 32'h0000_00E1);
            chk("stall_count", {16'b0, word_count}, 32'd1);
        end
        drive(1'b1, 8'hFF, 1'b1, 1'b0, 16'h0);
        after_edge();
        chk("release_out_data", {24'b0, out_data}, 32'h0000_003C);
        chk("release_count", {16'b0, word_count}, 32'd2);
`ifdef XOR_DESCRAMBLER_PARITY_EN
        chk("parity_3c", {31'b0, out_parity}, 32'd0);
`endif

        // Reseed with a real value, then with zero.
        drive(1'b1, 8'h77, 1'b1, 1'b1, 16'h1234);
        chk("seed_in_ready", {31'b0, in_ready}, 32'd0);
        after_edge();
        chk("seed_count", {16'b0, word_count}, 32'd2);
        drive(1'b1, 8'h34, 1'b1, 1'b0, 16'h0);
        after_edge();
        chk("seed1234_out", {24'b0, out_data}, 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 16'h0000);
        drive(1'b1, 8'hE1, 1'b1, 1'b0, 16'h0);
        after_edge();
        chk("seed0_out", {24'b0, out_data}, 32'd0);

        // Randomized traffic with occasional stalls and reseeds.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end

        // Asynchronous reset while holding a word.
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
        chk("pre_reset_full", {31'b0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_count", {16'b0, word_count}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h00, 1'b1, 1'b0, 16'h0);
        after_edge();
        chk("post_reset_out", {24'b0, out_data}, 32'h0000_00E1);

        // Counter wrap: 65535 more words bring word_count back to zero.
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 8'($urandom), 1'b1, 1'b0, 16'h0);
        end
        after_edge();
        chk("wrap_count", {16'b0, word_count}, 32'd0);
        chk("wrap_model", {16'b0, word_count}, {16'b0, m_count});

        drive(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
        after_edge();
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
